// File: rtl/cfu_acc_pkg.sv
// Shared op-codes and arithmetic helpers for the CFU accumulator bank.
package cfu_acc_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_WR_OFFSET = 3'd1;
    localparam logic [2:0] OP_CLEAR     = 3'd2;
    localparam logic [2:0] OP_ADD       = 3'd3;
    localparam logic [2:0] OP_MAC       = 3'd4;
    localparam logic [2:0] OP_READ      = 3'd5;
    localparam logic [2:0] OP_READ_CLR  = 3'd6;

    // Width of the full-precision dot-product sum: biased lane, times a byte, summed over lanes.
    function automatic int lane_sum_width(input int offset_width, input int lanes);
        int biased_w;
        biased_w = (offset_width > 8 ? offset_width : 8) + 1;
        return biased_w + 8 + $clog2(lanes);
    endfunction

    // Signed add clamped to a width-bit range; returns {overflow, clamped result}.
    function automatic logic [64:0] sat_add(input longint a, input longint b, input int width);
        longint sum;
        longint hi;
        longint lo;
        sum = a + b;
        hi  = (longint'(1) <<< (width - 1)) - 1;
        lo  = -hi - 1;
        if (sum > hi) return {1'b1, hi};
        if (sum < lo) return {1'b1, lo};
        return {1'b0, sum};
    endfunction

endpackage

// File: rtl/cfu_dot_lanes.sv
// Combinational LANES-wide int8 dot product with a signed input offset added to each in_a byte.
module cfu_dot_lanes
    import cfu_acc_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int OFFSET_WIDTH = 9,
    parameter int SUM_WIDTH    = lane_sum_width(OFFSET_WIDTH, LANES)
) (
    input  logic [LANES*8-1:0]             in_a,
    input  logic [LANES*8-1:0]             in_b,
    input  logic signed [OFFSET_WIDTH-1:0] offset,
    output logic signed [SUM_WIDTH-1:0]    sum
);

    localparam int BIAS_W = (OFFSET_WIDTH > 8 ? OFFSET_WIDTH : 8) + 1;
    localparam int PROD_W = BIAS_W + 8;

    logic signed [PROD_W-1:0] prod [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [7:0]        a_byte;
        logic signed [7:0]        b_byte;
        logic signed [BIAS_W-1:0] biased;
        assign a_byte  = in_a[i*8 +: 8];
        assign b_byte  = in_b[i*8 +: 8];
        assign biased  = BIAS_W'(a_byte) + BIAS_W'(offset);
        assign prod[i] = PROD_W'(biased) * PROD_W'(b_byte);
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + SUM_WIDTH'(prod[i]);
        end
    end

endmodule

// File: rtl/cfu_acc_bank.sv
// Bank of NUM_ACC signed accumulators with a shared input offset, fed by a 2-stage command pipeline.
module cfu_acc_bank
    import cfu_acc_pkg::*;
#(
    parameter int NUM_ACC      = 4,
    parameter int ACC_WIDTH    = 32,
    parameter int LANES        = 4,
    parameter int OFFSET_WIDTH = 9,
    parameter int SATURATE     = 0
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              cmd_valid,
    input  logic [2:0]                                        cmd_op,
    input  logic [(NUM_ACC > 1 ? $clog2(NUM_ACC) : 1)-1:0]    cmd_sel,
    input  logic [LANES*8-1:0]                                in_a,
    input  logic [LANES*8-1:0]                                in_b,
    output logic                                              rsp_valid,
    output logic [ACC_WIDTH-1:0]                              rsp_data,
    output logic                                              sat_flag,
    input  logic                                              clear_sat
);

    localparam int SEL_W = NUM_ACC > 1 ? $clog2(NUM_ACC) : 1;
    localparam int IN_W  = LANES * 8;
    localparam int SUM_W = lane_sum_width(OFFSET_WIDTH, LANES);
    localparam logic [SEL_W-1:0] SEL_MASK = SEL_W'(NUM_ACC - 1);

    logic signed [OFFSET_WIDTH-1:0] offset;
    logic signed [SUM_W-1:0]        dot_sum;
    logic signed [ACC_WIDTH-1:0]    add_val;

    logic                           s1_valid;
    logic [2:0]                     s1_op;
    logic [SEL_W-1:0]               s1_sel;
    logic signed [SUM_W-1:0]        s1_mac;
    logic signed [ACC_WIDTH-1:0]    s1_add;

    logic signed [ACC_WIDTH-1:0]    acc [NUM_ACC];

    logic [SEL_W-1:0]               idx;
    logic signed [ACC_WIDTH-1:0]    acc_rd;
    logic signed [ACC_WIDTH:0]      op_ext;
    logic [ACC_WIDTH-1:0]           wrap_val;
    logic [64:0]                    sat_res;
    logic [63-ACC_WIDTH:0]          unused_sat_hi;
    logic [ACC_WIDTH-1:0]           acc_next;
    logic                           sat_event;

    cfu_dot_lanes #(
        .LANES        (LANES),
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .SUM_WIDTH    (SUM_W)
    ) u_dot (
        .in_a   (in_a),
        .in_b   (in_b),
        .offset (offset),
        .sum    (dot_sum)
    );

    if (ACC_WIDTH <= IN_W) begin : g_add_trunc
        assign add_val = in_a[ACC_WIDTH-1:0];
    end else begin : g_add_sext
        assign add_val = {{(ACC_WIDTH - IN_W){in_a[IN_W-1]}}, in_a};
    end

    // Offset updates at the same edge as stage 1, so only commands issued afterwards see it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOP;
            s1_sel   <= '0;
            s1_mac   <= '0;
            s1_add   <= '0;
            offset   <= '0;
        end else begin
            s1_valid <= cmd_valid;
            s1_op    <= cmd_op;
            s1_sel   <= cmd_sel;
            s1_mac   <= dot_sum;
            s1_add   <= add_val;
            if (cmd_valid && cmd_op == OP_WR_OFFSET) begin
                offset <= in_a[OFFSET_WIDTH-1:0];
            end
        end
    end

    assign idx           = s1_sel & SEL_MASK;
    assign acc_rd        = acc[idx];
    assign op_ext        = (s1_op == OP_ADD) ? (ACC_WIDTH + 1)'(s1_add) : (ACC_WIDTH + 1)'(s1_mac);
    assign wrap_val      = acc_rd + op_ext[ACC_WIDTH-1:0];
    assign sat_res       = sat_add(64'(acc_rd), 64'(op_ext), ACC_WIDTH);
    assign unused_sat_hi = sat_res[63:ACC_WIDTH];
    assign acc_next      = (SATURATE != 0) ? sat_res[ACC_WIDTH-1:0] : wrap_val;
    assign sat_event     = (SATURATE != 0) && s1_valid &&
                           (s1_op == OP_ADD || s1_op == OP_MAC) && sat_res[64];

    // All accumulator traffic lives in this stage, so back-to-back commands never race.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc[i] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            rsp_valid <= s1_valid && (s1_op == OP_READ || s1_op == OP_READ_CLR);
            if (s1_valid) begin
                case (s1_op)
                    OP_CLEAR:       acc[idx] <= '0;
                    OP_ADD, OP_MAC: acc[idx] <= acc_next;
                    OP_READ:        rsp_data <= acc_rd;
                    OP_READ_CLR: begin
                        rsp_data <= acc_rd;
                        acc[idx] <= '0;
                    end
                    default: ;
                endcase
            end
            if (sat_event) begin
                sat_flag <= 1'b1;
            end else if (clear_sat) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cfu_acc_bank.sv
// Directed bench: wrapping and saturating accumulator banks driven by the same command stream.
module tb_cfu_acc_bank;
    import cfu_acc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_sel;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        clear_sat;

    logic        rsp_valid_w, rsp_valid_s;
    logic [31:0] rsp_data_w, rsp_data_s;
    logic        sat_flag_w, sat_flag_s;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cfu_acc_bank #(
        .NUM_ACC(4), .ACC_WIDTH(32), .LANES(4), .OFFSET_WIDTH(9), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
        .in_a(in_a), .in_b(in_b), .rsp_valid(rsp_valid_w), .rsp_data(rsp_data_w),
        .sat_flag(sat_flag_w), .clear_sat(clear_sat)
    );

    cfu_acc_bank #(
        .NUM_ACC(4), .ACC_WIDTH(32), .LANES(4), .OFFSET_WIDTH(9), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
        .in_a(in_a), .in_b(in_b), .rsp_valid(rsp_valid_s), .rsp_data(rsp_data_s),
        .sat_flag(sat_flag_s), .clear_sat(clear_sat)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled at the same point.
    task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [1:0] sel,
                                 input logic [31:0] a, input logic [31:0] b);
        cmd_valid = valid;
        cmd_op    = op;
        cmd_sel   = sel;
        in_a      = a;
        in_b      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic issueRead(input logic [2:0] op, input logic [1:0] sel,
                             input logic [31:0] exp_w, input logic [31:0] exp_s, input string tag);
        applyStimulus(1'b1, op, sel, 32'h0, 32'h0);
        checkOutput({tag, " valid+1 wrap"}, 32'(rsp_valid_w), 32'd0);
        checkOutput({tag, " valid+1 sat"}, 32'(rsp_valid_s), 32'd0);
        applyStimulus(1'b1, OP_NOP, 2'd0, 32'h0, 32'h0);
        checkOutput({tag, " valid+2 wrap"}, 32'(rsp_valid_w), 32'd1);
        checkOutput({tag, " valid+2 sat"}, 32'(rsp_valid_s), 32'd1);
        checkOutput({tag, " data wrap"}, rsp_data_w, exp_w);
        checkOutput({tag, " data sat"}, rsp_data_s, exp_s);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_sel   = 2'd0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        clear_sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset rsp_valid wrap", 32'(rsp_valid_w), 32'd0);
        checkOutput("reset rsp_valid sat", 32'(rsp_valid_s), 32'd0);
        checkOutput("reset rsp_data wrap", rsp_data_w, 32'd0);
        checkOutput("reset rsp_data sat", rsp_data_s, 32'd0);
        checkOutput("reset sat_flag sat", 32'(sat_flag_s), 32'd0);
        reset = 1'b0;

        for (int s = 0; s < 4; s++) begin
            issueRead(OP_READ, 2'(s), 32'd0, 32'd0, $sformatf("init read sel%0d", s));
        end

        // Offset 128: (4+128)+(3+128)+(2+128)+(1+128) = 522
        applyStimulus(1'b1, OP_WR_OFFSET, 2'd0, 32'h0000_0080, 32'h0);
        applyStimulus(1'b1, OP_MAC, 2'd1, 32'h0102_0304, 32'h0101_0101);
        issueRead(OP_READ, 2'd1, 32'd522, 32'd522, "mac offset128");
        applyStimulus(1'b0, OP_NOP, 2'd0, 32'h0, 32'h0);
        checkOutput("hold valid", 32'(rsp_valid_w), 32'd0);
        checkOutput("hold data", rsp_data_w, 32'd522);

        // Three back-to-back MACs of 4*127*127 each
        applyStimulus(1'b1, OP_WR_OFFSET, 2'd0, 32'h0, 32'h0);
        repeat (3) applyStimulus(1'b1, OP_MAC, 2'd2, 32'h7F7F_7F7F, 32'h7F7F_7F7F);
        issueRead(OP_READ_CLR, 2'd2, 32'd193548, 32'd193548, "read_clr sel2");
        issueRead(OP_READ, 2'd2, 32'd0, 32'd0, "after clr sel2");

        // MAC before the offset write sees 0 (adds 20), MAC after sees -5 (adds 0)
        applyStimulus(1'b1, OP_MAC, 2'd0, 32'h0505_0505, 32'h0101_0101);
        applyStimulus(1'b1, OP_WR_OFFSET, 2'd0, 32'h0000_01FB, 32'h0);
        applyStimulus(1'b1, OP_MAC, 2'd0, 32'h0505_0505, 32'h0101_0101);
        applyStimulus(1'b0, OP_ADD, 2'd0, 32'd1000, 32'h0);
        applyStimulus(1'b1, 3'd7, 2'd0, 32'd1000, 32'h0);
        issueRead(OP_READ, 2'd0, 32'd20, 32'd20, "offset timing sel0");

        applyStimulus(1'b1, OP_ADD, 2'd3, 32'h7FFF_FFF0, 32'h0);
        applyStimulus(1'b1, OP_ADD, 2'd3, 32'h0000_0020, 32'h0);
        issueRead(OP_READ, 2'd3, 32'h8000_0010, 32'h7FFF_FFFF, "overflow sel3");
        checkOutput("sat_flag set sat", 32'(sat_flag_s), 32'd1);
        checkOutput("sat_flag wrap", 32'(sat_flag_w), 32'd0);
        clear_sat = 1'b1;
        applyStimulus(1'b0, OP_NOP, 2'd0, 32'h0, 32'h0);
        clear_sat = 1'b0;
        checkOutput("sat_flag cleared", 32'(sat_flag_s), 32'd0);

        applyStimulus(1'b1, OP_ADD, 2'd3, 32'h7FFF_FFF0, 32'h0);
        applyStimulus(1'b0, OP_NOP, 2'd0, 32'h0, 32'h0);
        checkOutput("sat_flag reset", 32'(sat_flag_s), 32'd1);

        // Reset lands while a READ is in stage 1; its response must never appear
        applyStimulus(1'b1, OP_READ, 2'd1, 32'h0, 32'h0);
        reset = 1'b1;
        applyStimulus(1'b0, OP_NOP, 2'd0, 32'h0, 32'h0);
        checkOutput("reset kill valid wrap", 32'(rsp_valid_w), 32'd0);
        checkOutput("reset kill valid sat", 32'(rsp_valid_s), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, OP_NOP, 2'd0, 32'h0, 32'h0);
        checkOutput("post reset valid", 32'(rsp_valid_w), 32'd0);
        checkOutput("post reset sat_flag", 32'(sat_flag_s), 32'd0);
        for (int s = 0; s < 4; s++) begin
            issueRead(OP_READ, 2'(s), 32'd0, 32'd0, $sformatf("post reset sel%0d", s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
